// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: ripple-carry adder/subtractor, one WIDTH/STAGES-bit chunk per stage
// Valid/ready handshake with a global stall. Carry, overflow and sum come from the final stage.
module pipelined_add_sub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);
    localparam int C = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || WIDTH % STAGES != 0) begin : g_geometry_check
        $error("pipelined_add_sub: WIDTH must be divisible by STAGES and 1 <= STAGES <= WIDTH");
    end

    logic             v_q [STAGES];
    logic             v_d [STAGES];
    logic             c_q [STAGES];
    logic             c_d [STAGES];
    logic             as_q[STAGES];
    logic             as_d[STAGES];
    logic             bs_q[STAGES];
    logic             bs_d[STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic             ov_q;
    logic             ov_d;
    logic             stall;

    assign stall = v_q[STAGES-1] && !out_ready;

    // Unprocessed operand bits are kept right-aligned, so every stage adds bits [C-1:0].
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] s_in;
        logic             ci;
        logic             xs;
        logic             ys;
        logic [C:0]       t;
        if (k == 0) begin : g_first
            assign x     = a;
            assign y     = sub ? ~b : b;
            assign ci    = sub;
            assign s_in  = '0;
            assign xs    = a[WIDTH-1];
            assign ys    = y[WIDTH-1];
            assign v_d[k] = in_valid;
        end else begin : g_next
            assign x     = a_q[k-1];
            assign y     = b_q[k-1];
            assign ci    = c_q[k-1];
            assign s_in  = s_q[k-1];
            assign xs    = as_q[k-1];
            assign ys    = bs_q[k-1];
            assign v_d[k] = v_q[k-1];
        end
        assign t       = {1'b0, x[C-1:0]} + {1'b0, y[C-1:0]} + (C+1)'(ci);
        assign s_d[k]  = s_in | (WIDTH'(t[C-1:0]) << (k * C));
        assign a_d[k]  = x >> C;
        assign b_d[k]  = y >> C;
        assign c_d[k]  = t[C];
        assign as_d[k] = xs;
        assign bs_d[k] = ys;
    end

    assign ov_d = (as_d[STAGES-1] == bs_d[STAGES-1]) && (s_d[STAGES-1][WIDTH-1] != as_d[STAGES-1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q  <= '{default: '0};
            c_q  <= '{default: '0};
            as_q <= '{default: '0};
            bs_q <= '{default: '0};
            s_q  <= '{default: '0};
            a_q  <= '{default: '0};
            b_q  <= '{default: '0};
            ov_q <= 1'b0;
        end else if (!stall) begin
            v_q  <= v_d;
            c_q  <= c_d;
            as_q <= as_d;
            bs_q <= bs_d;
            s_q  <= s_d;
            a_q  <= a_d;
            b_q  <= b_d;
            ov_q <= ov_d;
        end
    end

    assign in_ready  = !stall;
    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign carry     = c_q[STAGES-1];
    assign overflow  = ov_q;
    assign zero      = (sum == '0);
endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb_pipelined_add_sub: random and directed stimulus on three geometries (32/4, 8/1, 16/16)
// checked every cycle against a delay-line model built on plain integer arithmetic.
module tb_pipelined_add_sub;
    logic        clk = 0;
    logic        reset = 1;
    logic        in_valid = 0;
    logic        sub = 0;
    logic        out_ready = 1;
    logic [31:0] a = 0;
    logic [31:0] b = 0;

    wire [2:0]  rdy, vld, cy, ovf, zr;
    wire [31:0] s32;
    wire [7:0]  s8;
    wire [15:0] s16;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipelined_add_sub #(.WIDTH(32), .STAGES(4)) u32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
        .a(a), .b(b), .sub(sub), .out_valid(vld[0]), .out_ready(out_ready),
        .sum(s32), .carry(cy[0]), .overflow(ovf[0]), .zero(zr[0]));

    pipelined_add_sub #(.WIDTH(8), .STAGES(1)) u8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]),
        .a(a[7:0]), .b(b[7:0]), .sub(sub), .out_valid(vld[1]), .out_ready(out_ready),
        .sum(s8), .carry(cy[1]), .overflow(ovf[1]), .zero(zr[1]));

    pipelined_add_sub #(.WIDTH(16), .STAGES(16)) u16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[2]),
        .a(a[15:0]), .b(b[15:0]), .sub(sub), .out_valid(vld[2]), .out_ready(out_ready),
        .sum(s16), .carry(cy[2]), .overflow(ovf[2]), .zero(zr[2]));

    function automatic logic [31:0] so(input int i);
        return i == 0 ? s32 : i == 1 ? {24'h0, s8} : {16'h0, s16};
    endfunction

    // Returns {overflow, carry, sum} for a w-bit add/sub.
    function automatic logic [33:0] ref_op(input logic [31:0] x, input logic [31:0] y, input logic s, input int w);
        logic [32:0] m, yb, t;
        logic [31:0] r;
        m  = (33'd1 << w) - 33'd1;
        yb = (s ? ~{1'b0, y} : {1'b0, y}) & m;
        t  = ({1'b0, x} & m) + yb + {32'h0, s};
        r  = t[31:0] & m[31:0];
        return {(x[w-1] == yb[w-1]) && (r[w-1] != x[w-1]), t[w], r};
    endfunction

    task automatic chk(input int id, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] @%0t: got %0h expected %0h", nm, id, $time, act, exp);
        end
    endtask

    int   dep[3] = '{4, 1, 16};
    int   wid[3] = '{32, 8, 16};
    logic        mv[3][16];
    logic [33:0] mr[3][16];
    bit          rs[3];
    bit          started = 0;

    always @(posedge clk) begin
        started = 1;
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                for (int k = 0; k < 16; k++) mv[i][k] = 1'b0;
                rs[i] = 1;
            end else begin
                rs[i] = 0;
                if (!(mv[i][dep[i]-1] && !out_ready)) begin
                    for (int k = 15; k > 0; k--) begin
                        mv[i][k] = mv[i][k-1];
                        mr[i][k] = mr[i][k-1];
                    end
                    mv[i][0] = in_valid;
                    mr[i][0] = ref_op(a, b, sub, wid[i]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                logic        ev;
                logic [33:0] er;
                ev = mv[i][dep[i]-1];
                er = mr[i][dep[i]-1];
                chk(i, "out_valid", vld[i], ev);
                chk(i, "in_ready", rdy[i], !(ev && !out_ready));
                if (ev) begin
                    chk(i, "sum", so(i), er[31:0]);
                    chk(i, "carry", cy[i], er[32]);
                    chk(i, "overflow", ovf[i], er[33]);
                    chk(i, "zero", zr[i], er[31:0] == 32'h0);
                end
                if (rs[i]) begin
                    chk(i, "rst_sum", so(i), 0);
                    chk(i, "rst_carry", cy[i], 0);
                    chk(i, "rst_overflow", ovf[i], 0);
                    chk(i, "rst_zero", zr[i], 1);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s);
        bit acc = 0;
        int n = 0;
        in_valid = 1;
        a = x;
        b = y;
        sub = s;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = rdy[0];
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk(0, "issue_timeout", 0, 1);
        in_valid = 0;
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Literal latency/value check on the 32-bit, 4-stage instance.
    task automatic lat_check(input logic [31:0] x, input logic [31:0] y, input logic s, input logic [34:0] exp);
        issue(x, y, s);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk(0, "lat_early", vld[0], 0);
        @(posedge clk);
        @(negedge clk);
        chk(0, "lat_valid", vld[0], 1);
        chk(0, "lat_sum", s32, exp[31:0]);
        chk(0, "lat_carry", cy[0], exp[32]);
        chk(0, "lat_overflow", ovf[0], exp[33]);
        chk(0, "lat_zero", zr[0], exp[34]);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 8)
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int stall_cnt = 0;
        reset = 1;
        in_valid = 1;
        a = 32'h1234_5678;
        b = 32'h1;
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        in_valid = 0;

        chk(0, "model_wrap", ref_op(32'hFFFF_FFFF, 32'h1, 0, 32), {1'b0, 1'b1, 32'h0});
        chk(0, "model_ovf_add", ref_op(32'h7FFF_FFFF, 32'h1, 0, 32), {1'b1, 1'b0, 32'h8000_0000});
        chk(0, "model_borrow", ref_op(32'h0, 32'h1, 1, 32), {1'b0, 1'b0, 32'hFFFF_FFFF});
        chk(0, "model_ovf_sub", ref_op(32'h8000_0000, 32'h1, 1, 32), {1'b1, 1'b1, 32'h7FFF_FFFF});
        chk(0, "model_sub_neg", ref_op(32'd3, 32'd10, 1, 32), {1'b0, 1'b0, 32'hFFFF_FFF9});
        chk(1, "model_wrap8", ref_op(32'hFF, 32'h1, 0, 8), {1'b0, 1'b1, 32'h0});

        repeat (4) begin
            @(negedge clk);
            chk(0, "post_reset_quiet", vld[0], 0);
        end
        @(posedge clk);
        #1;

        lat_check(32'd5, 32'd3, 0, {1'b0, 1'b0, 1'b0, 32'd8});
        lat_check(32'hFFFF_FFFF, 32'h1, 0, {1'b1, 1'b0, 1'b1, 32'h0});
        lat_check(32'h8000_0000, 32'h1, 1, {1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF});

        issue(32'h00FF_00FF, 32'h0001_0001, 0);
        issue(32'h7FFF_FFFF, 32'h1, 0);
        issue(32'd10, 32'd3, 1);
        issue(32'd3, 32'd10, 1);
        issue(32'h0, 32'h1, 1);
        idle(20);

        fork
            for (int i = 1; i <= 8; i++) issue(i, 2 * i, 0);
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1;
            end
            repeat (16) begin
                @(negedge clk);
                if (!rdy[0]) stall_cnt++;
            end
        join
        chk(0, "stall_cycles", stall_cnt, 3);
        idle(25);

        issue(32'd1, 32'd2, 0);
        issue(32'd3, 32'd4, 0);
        issue(32'd5, 32'd6, 0);
        reset = 1;
        @(posedge clk);
        #1 reset = 0;
        repeat (6) begin
            @(negedge clk);
            chk(0, "flushed", vld[0], 0);
        end
        @(posedge clk);
        #1;
        lat_check(32'd100, 32'd23, 0, {1'b0, 1'b0, 1'b0, 32'd123});

        repeat (3000) begin
            in_valid  = ($urandom % 4) != 0;
            a         = pick();
            b         = pick();
            sub       = $urandom % 2;
            out_ready = ($urandom % 4) != 0;
            reset     = ($urandom % 300) == 0;
            @(posedge clk);
            #1;
        end
        reset = 0;
        out_ready = 1;
        idle(25);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
